// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
// The high-phase helper works on 32-bit values, so counter widths are limited to 32.
package clk_div_pkg;

    localparam int CW_DEFAULT      = 26;
    localparam int DEF_DIV_DEFAULT = 100000;

    // Length of the high phase; odd divisors get the extra cycle in the low phase.
    function automatic logic [31:0] high_len(input logic [31:0] d);
        return d >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active/pending divisor, period counter and registered outputs.
// Divisor changes only land at a wrap or a sync restart, so periods are never cut short.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CW      = CW_DEFAULT,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          sync,
    input  logic          load,
    input  logic [CW-1:0] load_div,
    output logic          div_out,
    output logic          tick
);

    localparam logic [CW-1:0] RST_DIV = CW'(DEF_DIV);
    localparam logic [CW-1:0] MIN_DIV = CW'(2);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] act_q, act_d;
    logic [CW-1:0] pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          run_q, run_d;
    logic          div_out_q, div_out_d;
    logic          tick_q, tick_d;

    logic [CW-1:0] pend_n;
    logic          pending_n;
    logic          restart;
    logic [CW-1:0] half;

    always_comb begin
        act_d     = act_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        cnt_d     = '0;
        run_d     = 1'b0;
        restart   = 1'b0;
        pend_n    = load ? load_div : pend_q;
        pending_n = load | pending_q;

        if (!run_q) begin
            // Stopped: a load is applied at once and a valid divisor starts a fresh period.
            if (load) begin
                act_d     = load_div;
                pending_d = 1'b0;
            end
            run_d = en && (act_d >= MIN_DIV);
        end else if (!en) begin
            pend_d    = pend_n;
            pending_d = pending_n;
        end else begin
            restart = sync || (cnt_q == act_q - ONE);
            if (restart) begin
                act_d     = pending_n ? pend_n : act_q;
                pend_d    = pend_n;
                pending_d = 1'b0;
            end else begin
                cnt_d     = cnt_q + ONE;
                pend_d    = pend_n;
                pending_d = pending_n;
            end
            run_d = (act_d >= MIN_DIV);
            if (!run_d) begin
                cnt_d = '0;
            end
        end

        half      = CW'(high_len(32'(act_d)));
        tick_d    = run_d && (cnt_d == '0);
        div_out_d = run_d && (cnt_d < half);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q     <= RST_DIV;
            pend_q    <= RST_DIV;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            div_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            act_q     <= act_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
        end
    end

    assign div_out = div_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: decodes divisor loads to one channel
// and fans the phase-align strobe out to all of them.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int CW      = CW_DEFAULT,
    parameter  int DEF_DIV = DEF_DIV_DEFAULT,
    localparam int CHW     = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           load,
    input  logic [CHW-1:0] load_ch,
    input  logic [CW-1:0]  load_div,
    output logic [NCH-1:0] div_out,
    output logic [NCH-1:0] tick
);

    localparam int unsigned NCH_U = NCH;

    logic load_ok;

    // Indices past the last channel are dropped rather than aliased.
    assign load_ok = load && (32'(load_ch) < NCH_U);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic hit;
            assign hit = load_ok && (load_ch == CHW'(gi));

            clk_div_chan #(
                .CW      (CW),
                .DEF_DIV (DEF_DIV)
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en[gi]),
                .sync     (sync),
                .load     (hit),
                .load_div (load_div),
                .div_out  (div_out[gi]),
                .tick     (tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: expected per-cycle tick/div_out vectors are
// queued from ideal waveforms when stimulus is applied, then popped against the DUT.
module tb_clk_div_multi;

    localparam int NCH     = 5;
    localparam int CW      = 26;
    localparam int DEF_DIV = 10;
    localparam int CHW     = $clog2(NCH);

    typedef int div_arr_t [NCH];
    typedef struct {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] div;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] en = '0;
    logic           sync = 1'b0;
    logic           load = 1'b0;
    logic [CHW-1:0] load_ch = '0;
    logic [CW-1:0]  load_div = '0;
    logic [NCH-1:0] div_out;
    logic [NCH-1:0] tick;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q [$];

    clk_div_multi #(
        .NCH     (NCH),
        .CW      (CW),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .load     (load),
        .load_ch  (load_ch),
        .load_div (load_div),
        .div_out  (div_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Ideal output of a channel with period d at position c of its period train.
    function automatic logic [1:0] wave(input int d, input int c);
        if (d < 2 || c < 0) return 2'b00;
        return {(c % d) == 0, (c % d) < (d / 2)};
    endfunction

    task automatic push_run(input int n, input div_arr_t d, input div_arr_t ph);
        exp_t       e;
        logic [1:0] w;
        for (int i = 0; i < n; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                w = wave(d[ch], i + ph[ch]);
                e.tick[ch] = w[1];
                e.div[ch]  = w[0];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic set_load(input int ch, input int div);
        load     = 1'b1;
        load_ch  = CHW'(ch);
        load_div = CW'(div);
        $display("load ch=%0d div=%0d t=%0t", ch, div, $time);
    endtask

    task automatic do_load(input int ch, input int div);
        set_load(ch, div);
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = '0;
        cyc();
        cyc();
        checks++;
        if (tick !== '0) begin
            failures++;
            $display("FAIL reset_tick got=%b exp=%b", tick, {NCH{1'b0}});
        end
        checks++;
        if (div_out !== '0) begin
            failures++;
            $display("FAIL reset_div got=%b exp=%b", div_out, {NCH{1'b0}});
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if (tick !== '0 || div_out !== '0) begin
            failures++;
            $display("FAIL reset_idle tick=%b div=%b exp=0/0", tick, div_out);
        end
        $display("reset done t=%0t", $time);
    endtask

    task automatic test_basic();
        div_arr_t d  = '{10, 0, 0, 0, 0};
        div_arr_t ph = '{0, 0, 0, 0, 0};
        exp_t     e;
        en = 5'b00001;
        $display("enable ch0 t=%0t", $time);
        push_run(30, d, ph);
        for (int i = 0; i < 30; i++) begin
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (tick !== e.tick || div_out !== e.div) begin
                failures++;
                $display("FAIL basic cyc=%0d tick=%b exp=%b div=%b exp=%b", i, tick, e.tick, div_out, e.div);
            end
        end
    endtask

    task automatic test_load_stopped();
        div_arr_t d7 = '{0, 7, 0, 0, 0};
        div_arr_t d2 = '{0, 2, 0, 0, 0};
        div_arr_t ph = '{0, 0, 0, 0, 0};
        exp_t     e;
        en = '0;
        cyc();
        do_load(1, 7);
        en = 5'b00010;
        push_run(21, d7, ph);
        for (int i = 0; i < 21; i++) begin
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (tick !== e.tick || div_out !== e.div) begin
                failures++;
                $display("FAIL load_d7 cyc=%0d tick=%b exp=%b div=%b exp=%b", i, tick, e.tick, div_out, e.div);
            end
        end
        en = '0;
        cyc();
        do_load(1, 2);
        en = 5'b00010;
        push_run(10, d2, ph);
        for (int i = 0; i < 10; i++) begin
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (tick !== e.tick || div_out !== e.div) begin
                failures++;
                $display("FAIL load_d2 cyc=%0d tick=%b exp=%b div=%b exp=%b", i, tick, e.tick, div_out, e.div);
            end
        end
    endtask

    task automatic test_pending();
        exp_t       e;
        logic [1:0] w;
        en = '0;
        cyc();
        en = 5'b00001;
        for (int i = 0; i < 22; i++) begin
            w = (i < 10) ? wave(10, i) : wave(4, i - 10);
            e.tick = '0;
            e.div  = '0;
            e.tick[0] = w[1];
            e.div[0]  = w[0];
            exp_q.push_back(e);
        end
        for (int i = 0; i < 22; i++) begin
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (tick !== e.tick || div_out !== e.div) begin
                failures++;
                $display("FAIL pending cyc=%0d tick=%b exp=%b div=%b exp=%b", i, tick, e.tick, div_out, e.div);
            end
            if (i == 3) set_load(0, 4);
            if (i == 4) load = 1'b0;
        end
    endtask

    task automatic test_sync();
        div_arr_t d_a = '{6, 9, 10, 0, 0};
        div_arr_t d_b = '{4, 9, 10, 0, 0};
        div_arr_t ph  = '{0, 0, 0, 0, 0};
        exp_t     e;
        en = '0;
        cyc();
        do_load(0, 6);
        do_load(1, 9);
        do_load(2, 10);
        en = 5'b00001;
        cyc();
        cyc();
        en[1] = 1'b1;
        cyc();
        cyc();
        cyc();
        en[2] = 1'b1;
        cyc();
        checks++;
        if (tick !== 5'b00100) begin
            failures++;
            $display("FAIL stagger_tick got=%b exp=%b", tick, 5'b00100);
        end
        cyc();
        cyc();
        sync = 1'b1;
        $display("sync t=%0t", $time);
        push_run(30, d_a, ph);
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (i == 0) sync = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (tick !== e.tick || div_out !== e.div) begin
                failures++;
                $display("FAIL sync cyc=%0d tick=%b exp=%b div=%b exp=%b", i, tick, e.tick, div_out, e.div);
            end
        end
        set_load(0, 4);
        sync = 1'b1;
        $display("sync+load t=%0t", $time);
        push_run(20, d_b, ph);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (i == 0) begin
                sync = 1'b0;
                load = 1'b0;
            end
            e = exp_q.pop_front();
            checks++;
            if (tick !== e.tick || div_out !== e.div) begin
                failures++;
                $display("FAIL sync_load cyc=%0d tick=%b exp=%b div=%b exp=%b", i, tick, e.tick, div_out, e.div);
            end
        end
    endtask

    task automatic test_stop_invalid();
        exp_t       e;
        logic [1:0] w0, w1, w2;
        sync = 1'b1;
        $display("sync t=%0t", $time);
        for (int i = 0; i < 36; i++) begin
            w0 = wave(4, i);
            w1 = wave(9, i);
            if (i < 10)      w2 = wave(10, i);
            else if (i < 20) w2 = 2'b00;
            else             w2 = wave(5, i - 20);
            e.tick = '0;
            e.div  = '0;
            e.tick[2:0] = {w2[1], w1[1], w0[1]};
            e.div[2:0]  = {w2[0], w1[0], w0[0]};
            exp_q.push_back(e);
        end
        for (int i = 0; i < 36; i++) begin
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (tick !== e.tick || div_out !== e.div) begin
                failures++;
                $display("FAIL stop_invalid cyc=%0d tick=%b exp=%b div=%b exp=%b", i, tick, e.tick, div_out, e.div);
            end
            case (i)
                0:  sync = 1'b0;
                3:  set_load(2, 1);
                4:  set_load(5, 3);
                5:  set_load(7, 2);
                6:  load = 1'b0;
                19: set_load(2, 5);
                20: load = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_en();
        exp_t       e;
        logic [1:0] w;
        en = '0;
        cyc();
        en = 5'b00001;
        cyc();
        cyc();
        checks++;
        if (div_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_high got=%b exp=1", div_out[0]);
        end
        #2;
        rst_n = 1'b0;
        $display("async reset t=%0t", $time);
        #1;
        checks++;
        if (tick !== '0 || div_out !== '0) begin
            failures++;
            $display("FAIL async_reset tick=%b div=%b exp=0/0", tick, div_out);
        end
        cyc();
        rst_n = 1'b1;
        en    = '1;
        for (int i = 0; i < 30; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (ch == 0 && i == 5)     w = 2'b00;
                else if (ch == 0 && i > 5) w = wave(DEF_DIV, i - 6);
                else                       w = wave(DEF_DIV, i);
                e.tick[ch] = w[1];
                e.div[ch]  = w[0];
            end
            exp_q.push_back(e);
        end
        for (int i = 0; i < 30; i++) begin
            cyc();
            e = exp_q.pop_front();
            checks++;
            if (tick !== e.tick || div_out !== e.div) begin
                failures++;
                $display("FAIL reset_en cyc=%0d tick=%b exp=%b div=%b exp=%b", i, tick, e.tick, div_out, e.div);
            end
            if (i == 4) en[0] = 1'b0;
            if (i == 5) en[0] = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_stopped();
        test_pending();
        test_sync();
        test_stop_invalid();
        test_reset_en();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
